// File: rtl/integrator_pkg.sv
// integrator_pkg
//   Shared definitions for the integrator datapath: default widths, the
//   dump-mode FSM state type and the saturation bound helpers used by the
//   adder.
package integrator_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ACC_W_DEF    = 16;
    localparam int DUMP_LEN_DEF = 16;

    // RUN accumulates samples; DUMP is the single cycle that publishes a window
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DUMP = 1'b1
    } state_e;

    // Largest positive value of a w-bit two's-complement number
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value of a w-bit two's-complement number
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/integrator_sat_add.sv
// sat_add
//   Combinational saturating adder: sign-extends the DATA_W delta to the
//   accumulator width, adds, and clamps to the signed ACC_W range.
// Ports
//   acc    in  ACC_W   signed accumulator operand
//   delta  in  DATA_W  signed delta operand
//   sum    out ACC_W   clamped sum
//   ovf    out 1       high when the true sum fell outside the ACC_W range
module sat_add
    import integrator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] delta,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W:0] wide_s;

    // One-bit-wider add; the two top bits disagree exactly when the ACC_W result overflowed
    always_comb begin
        wide_s = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DATA_W){delta[DATA_W-1]}}, delta};
        ovf    = (wide_s[ACC_W] != wide_s[ACC_W-1]);
        if (ovf) begin
            // The extra top bit carries the true sign of the unclamped result
            if (wide_s[ACC_W]) begin
                sum = MIN_V;
            end else begin
                sum = MAX_V;
            end
        end else begin
            sum = wide_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/integrator.sv
// integrator
//   Accumulates a signed delta stream back into an absolute signal with
//   saturation, either continuously or as integrate-and-dump windows of
//   DUMP_LEN samples.
// Ports
//   clk        in  1       rising-edge clock
//   reset      in  1       asynchronous active-low reset
//   enb        in  1       sample strobe, In consumed on each edge with enb=1
//   In         in  DATA_W  signed delta
//   clear      in  1       synchronous clear of accumulator, count, sat and Out
//   load       in  1       synchronous preset of accumulator and Out from load_val
//   load_val   in  ACC_W   signed preset value
//   dump_mode  in  1       0 = continuous, 1 = integrate-and-dump
//   Out        out ACC_W   running sum (continuous) or last window sum (dump)
//   out_valid  out 1       one-cycle pulse when Out was updated
//   sat        out 1       sticky saturation flag since last clear/reset
module integrator
    import integrator_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int DUMP_LEN = DUMP_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enb,
    input  logic signed [DATA_W-1:0] In,
    input  logic                     clear,
    input  logic                     load,
    input  logic signed [ACC_W-1:0]  load_val,
    input  logic                     dump_mode,
    output logic signed [ACC_W-1:0]  Out,
    output logic                     out_valid,
    output logic                     sat
);

    localparam int               CNT_W    = $clog2(DUMP_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_LEN);

    state_e                  state_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] out_r;
    logic [CNT_W-1:0]        count_r;
    logic                    valid_r;
    logic                    sat_r;

    logic                    in_dump_s;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    ovf_s;
    logic [CNT_W-1:0]        cnt_base_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    win_done_s;

    // Operand select: in the DUMP cycle a new window starts from zero, so a
    // sample arriving then becomes the first sample of the next window
    always_comb begin
        in_dump_s = (state_r == ST_DUMP);
        if (in_dump_s) begin
            base_s     = {ACC_W{1'b0}};
            cnt_base_s = {CNT_W{1'b0}};
        end else begin
            base_s     = acc_r;
            cnt_base_s = count_r;
        end
        cnt_inc_s  = cnt_base_s + CNT_W'(1);
        win_done_s = (cnt_inc_s == CNT_LAST);
    end

    sat_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc   (base_s),
        .delta (In),
        .sum   (sum_s),
        .ovf   (ovf_s)
    );

    // Accumulator, window count, FSM and registered outputs; clear > load > enb
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            acc_r   <= {ACC_W{1'b0}};
            out_r   <= {ACC_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            sat_r   <= 1'b0;
        end else if (clear) begin
            state_r <= ST_RUN;
            acc_r   <= {ACC_W{1'b0}};
            out_r   <= {ACC_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            sat_r   <= 1'b0;
        end else if (load) begin
            state_r <= ST_RUN;
            acc_r   <= load_val;
            out_r   <= load_val;
            count_r <= {CNT_W{1'b0}};
            valid_r <= 1'b1;
        end else if (in_dump_s) begin
            // Publish the finished window and restart accumulation
            out_r   <= acc_r;
            valid_r <= 1'b1;
            if (enb) begin
                acc_r   <= sum_s;
                count_r <= cnt_inc_s;
                // DUMP_LEN=1: the new sample already completes the next window
                state_r <= win_done_s ? ST_DUMP : ST_RUN;
            end else begin
                acc_r   <= {ACC_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
                state_r <= ST_RUN;
            end
        end else if (enb) begin
            acc_r <= sum_s;
            if (ovf_s) begin
                sat_r <= 1'b1;
            end else begin
                sat_r <= sat_r;
            end
            if (dump_mode) begin
                count_r <= cnt_inc_s;
                valid_r <= 1'b0;
                if (win_done_s) begin
                    state_r <= ST_DUMP;
                end else begin
                    state_r <= ST_RUN;
                end
            end else begin
                // Count is left alone so a window resumes if dump mode returns
                out_r   <= sum_s;
                valid_r <= 1'b1;
            end
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign Out       = out_r;
    assign out_valid = valid_r;
    assign sat       = sat_r;

endmodule
